// File: rtl/cursor_pkg.sv
// Shared types and constants for the cursor/rectangle overlay control path.
// State and direction encodings here are relied on by the LED debug outputs.
package cursor_pkg;

  localparam int COORD_W = 13;

  typedef enum logic [1:0] {
    R_OFF   = 2'd0,
    R_READY = 2'd1,
    R_LOCK1 = 2'd2,
    R_LOCK2 = 2'd3
  } rect_state_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_UP    = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  // pressed is active-high: [3] left, [2] up, [1] down, [0] right
  function automatic dir_e pick_dir(input logic [3:0] pressed);
    dir_e d;
    d = DIR_NONE;
    if (pressed[3])      d = DIR_LEFT;
    else if (pressed[2]) d = DIR_UP;
    else if (pressed[1]) d = DIR_DOWN;
    else if (pressed[0]) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/cursor_rect_ctrl_if.sv
// Cursor/rectangle bundle handed from the control sequencer to the overlay datapath.
// No handshake: fields are registered and always current; the overlay draws the
// rectangle only while rect_valid=1, and the bounds are stable whenever it is high.
interface cursor_rect_ctrl_if;
  import cursor_pkg::*;

  logic [COORD_W-1:0] c_row;
  logic [COORD_W-1:0] c_col;
  logic [COORD_W-1:0] rect_min_row;
  logic [COORD_W-1:0] rect_max_row;
  logic [COORD_W-1:0] rect_min_col;
  logic [COORD_W-1:0] rect_max_col;
  logic               rect_valid;
  logic [1:0]         rect_state;

  modport master (
    output c_row, c_col, rect_min_row, rect_max_row,
           rect_min_col, rect_max_col, rect_valid, rect_state
  );

  modport slave (
    input  c_row, c_col, rect_min_row, rect_max_row,
           rect_min_col, rect_max_col, rect_valid, rect_state
  );
endinterface

// File: rtl/cursor_rect_ctrl_key_debounce.sv
// Two-flop synchronizer followed by a stable-count filter for one switch or key.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_0;
  logic          sync_1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_0 <= RESET_VAL;
      sync_1 <= RESET_VAL;
      stable <= RESET_VAL;
      cnt    <= '0;
    end else begin
      sync_0 <= raw;
      sync_1 <= sync_0;
      if (sync_1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_rect_ctrl.sv
// Key-driven cursor with auto-repeat and wrap-around, plus the rectangle corner-lock FSM.
// Everything runs on CLOCK_50; outputs are registered for the overlay pixel datapath.
module cursor_rect_ctrl
  import cursor_pkg::*;
#(
  parameter int H_LIMIT         = 640,
  parameter int V_LIMIT         = 480,
  parameter int VELOCITY        = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2097152,
  parameter int HOME_ROW        = 240,
  parameter int HOME_COL        = 320
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [3:0]                KEY,
  input  logic                      cursor_en,
  input  logic                      draw_en,
  input  logic                      lock_sw,
  cursor_rect_ctrl_if.master        ovl
);

  localparam logic [COORD_W-1:0] H_L   = COORD_W'(H_LIMIT);
  localparam logic [COORD_W-1:0] V_L   = COORD_W'(V_LIMIT);
  localparam logic [COORD_W-1:0] VEL   = COORD_W'(VELOCITY);
  localparam logic [COORD_W-1:0] H_ROW = COORD_W'(HOME_ROW);
  localparam logic [COORD_W-1:0] H_COL = COORD_W'(HOME_COL);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [1:0] cen_sync, draw_sync;
  logic       cen_s, draw_s;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cen_sync  <= '0;
      draw_sync <= '0;
    end else begin
      cen_sync  <= {cen_sync[0], cursor_en};
      draw_sync <= {draw_sync[0], draw_en};
    end
  end
  assign cen_s  = cen_sync[1];
  assign draw_s = draw_sync[1];

  logic [3:0] key_stable;
  logic       lock_db;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_key (
      .clk(CLOCK_50), .reset(reset), .raw(KEY[k]), .stable(key_stable[k])
    );
  end

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_lock (
    .clk(CLOCK_50), .reset(reset), .raw(lock_sw), .stable(lock_db)
  );

  // Auto-repeat: immediate tick on a new direction, then REPEAT_DELAY, then every REPEAT_PERIOD.
  dir_e          dir, prev_dir;
  logic [RW-1:0] rep_cnt;
  logic          tick;

  assign dir  = pick_dir(~key_stable);
  assign tick = (dir != DIR_NONE) && ((dir != prev_dir) || (rep_cnt == '0));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prev_dir <= DIR_NONE;
      rep_cnt  <= '0;
    end else begin
      prev_dir <= dir;
      if (dir == DIR_NONE)        rep_cnt <= '0;
      else if (dir != prev_dir)   rep_cnt <= RW'(REPEAT_DELAY - 1);
      else if (rep_cnt == '0)     rep_cnt <= RW'(REPEAT_PERIOD - 1);
      else                        rep_cnt <= rep_cnt - RW'(1);
    end
  end

  logic [COORD_W-1:0] c_row, c_col;

  always_ff @(posedge CLOCK_50) begin
    if (reset || !cen_s) begin
      c_row <= H_ROW;
      c_col <= H_COL;
    end else if (tick) begin
      case (dir)
        DIR_LEFT:  c_col <= (c_col >= VEL) ? c_col - VEL : c_col + (H_L - VEL);
        DIR_RIGHT: c_col <= (c_col + VEL < H_L) ? c_col + VEL : c_col + VEL - H_L;
        DIR_UP:    c_row <= (c_row >= VEL) ? c_row - VEL : c_row + (V_L - VEL);
        DIR_DOWN:  c_row <= (c_row + VEL < V_L) ? c_row + VEL : c_row + VEL - V_L;
        default: ;
      endcase
    end
  end

  // Rectangle lock FSM
  rect_state_e state, state_nx;
  logic        lock_prev, lock_rise, lock_fall;
  logic        cap_p1, cap_p2;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= R_OFF;
      lock_prev <= 1'b0;
    end else begin
      state     <= state_nx;
      lock_prev <= lock_db;
    end
  end

  assign lock_rise = lock_db & ~lock_prev;
  assign lock_fall = ~lock_db & lock_prev;

  always_comb begin
    state_nx = state;
    cap_p1   = 1'b0;
    cap_p2   = 1'b0;
    if (!cen_s || !draw_s) begin
      state_nx = R_OFF;
    end else begin
      case (state)
        R_OFF:   state_nx = R_READY;
        R_READY: if (lock_rise) begin cap_p1 = 1'b1; state_nx = R_LOCK1; end
        R_LOCK1: if (lock_fall) begin cap_p2 = 1'b1; state_nx = R_LOCK2; end
        R_LOCK2: if (lock_rise) begin cap_p1 = 1'b1; state_nx = R_LOCK1; end
        default: state_nx = R_OFF;
      endcase
    end
  end

  // Corners take the position register as it stands, i.e. before a same-cycle move lands.
  logic [COORD_W-1:0] p1_row, p1_col, p2_row, p2_col;
  logic [COORD_W-1:0] min_row, max_row, min_col, max_col;
  logic               rect_valid, bounds_pend;

  always_ff @(posedge CLOCK_50) begin
    if (reset || state_nx == R_OFF) begin
      p1_row <= '0; p1_col <= '0; p2_row <= '0; p2_col <= '0;
      min_row <= '0; max_row <= '0; min_col <= '0; max_col <= '0;
      rect_valid  <= 1'b0;
      bounds_pend <= 1'b0;
    end else if (cap_p1) begin
      p1_row      <= c_row;
      p1_col      <= c_col;
      rect_valid  <= 1'b0;
      bounds_pend <= 1'b0;
    end else if (cap_p2) begin
      p2_row      <= c_row;
      p2_col      <= c_col;
      bounds_pend <= 1'b1;
    end else if (bounds_pend) begin
      min_row     <= (p1_row < p2_row) ? p1_row : p2_row;
      max_row     <= (p1_row < p2_row) ? p2_row : p1_row;
      min_col     <= (p1_col < p2_col) ? p1_col : p2_col;
      max_col     <= (p1_col < p2_col) ? p2_col : p1_col;
      rect_valid  <= 1'b1;
      bounds_pend <= 1'b0;
    end
  end

  assign ovl.c_row        = c_row;
  assign ovl.c_col        = c_col;
  assign ovl.rect_min_row = min_row;
  assign ovl.rect_max_row = max_row;
  assign ovl.rect_min_col = min_col;
  assign ovl.rect_max_col = max_col;
  assign ovl.rect_valid   = rect_valid;
  assign ovl.rect_state   = state;

endmodule

// File: tb/tb_cursor_rect_ctrl.sv
// Directed bench for cursor_rect_ctrl with short debounce/repeat timings.
// Expected positions and tick times are hand-computed from the key timing.
module tb_cursor_rect_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] KEY;
  logic       cursor_en, draw_en, lock_sw;

  int n_checks;
  int n_pass;

  cursor_rect_ctrl_if ovl();

  cursor_rect_ctrl #(
    .H_LIMIT(640), .V_LIMIT(480), .VELOCITY(8),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
    .HOME_ROW(240), .HOME_COL(320)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(KEY), .cursor_en(cursor_en),
    .draw_en(draw_en), .lock_sw(lock_sw), .ovl(ovl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Hold the keys in keys_pressed (active-high mask) long enough for exactly n ticks.
  // Ticks land 6, 26, 34, ... cycles after the press; release takes 6 cycles to be accepted.
  task automatic press(input logic [3:0] keys_pressed, input int n);
    int t_last;
    t_last = (n <= 1) ? 6 : 26 + 8 * (n - 2);
    KEY = ~keys_pressed;
    step(t_last + 2);
    KEY = 4'hf;
    step(10);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; KEY = 4'hf; cursor_en = 1'b1; draw_en = 1'b0; lock_sw = 1'b0;
    step(3);
    check("reset_row",   ovl.c_row, 240);
    check("reset_col",   ovl.c_col, 320);
    check("reset_valid", ovl.rect_valid, 0);
    check("reset_state", ovl.rect_state, 0);
    reset = 1'b0;
    step(2);

    // right key held: move after debounce, then after REPEAT_DELAY
    KEY = 4'b1110;
    step(6);  check("right_pre_debounce", ovl.c_col, 320);
    step(1);  check("right_first",        ovl.c_col, 328);
    step(19); check("right_before_rep",   ovl.c_col, 328);
    step(1);  check("right_first_rep",    ovl.c_col, 336);
    step(1);
    KEY = 4'hf;
    step(10); check("right_released",     ovl.c_col, 336);

    // down key glitch is filtered, then a long hold repeats
    KEY = 4'b1101; step(2); KEY = 4'hf; step(10);
    check("down_glitch", ovl.c_row, 240);
    KEY = 4'b1101;
    step(6);  check("down_pre",  ovl.c_row, 240);
    step(1);  check("down_t0",   ovl.c_row, 248);
    step(20); check("down_t1",   ovl.c_row, 256);
    step(8);  check("down_t2",   ovl.c_row, 264);
    step(8);  check("down_t3",   ovl.c_row, 272);
    step(8);  check("down_t4",   ovl.c_row, 280);
    step(1);
    KEY = 4'hf;
    step(10); check("down_released", ovl.c_row, 280);

    // wrap-around on both axes
    press(4'b1000, 42); check("left_to_zero",  ovl.c_col, 0);
    press(4'b1000, 1);  check("left_wrap",     ovl.c_col, 632);
    press(4'b0001, 1);  check("right_wrap",    ovl.c_col, 0);
    press(4'b0100, 35); check("up_to_zero",    ovl.c_row, 0);
    press(4'b0100, 1);  check("up_wrap",       ovl.c_row, 472);
    press(4'b0010, 1);  check("down_wrap",     ovl.c_row, 0);

    // cursor disable sends the cursor home
    cursor_en = 1'b0;
    step(4);
    check("disable_row", ovl.c_row, 240);
    check("disable_col", ovl.c_col, 320);
    cursor_en = 1'b1;
    step(3);

    // left beats right when both are pressed
    press(4'b1001, 1);
    check("prio_col", ovl.c_col, 312);
    check("prio_row", ovl.c_row, 240);

    // rectangle sequence from home
    reset = 1'b1; step(1); reset = 1'b0; step(3);
    draw_en = 1'b1;
    step(4);  check("rect_ready", ovl.rect_state, 1);
    lock_sw = 1'b1;
    step(7);  check("rect_lock1", ovl.rect_state, 2);
    press(4'b0100, 5);
    press(4'b0001, 5);
    check("rect_move_row", ovl.c_row, 200);
    check("rect_move_col", ovl.c_col, 360);
    check("rect_still_lock1", ovl.rect_state, 2);
    lock_sw = 1'b0;
    step(7);
    check("rect_lock2",        ovl.rect_state, 3);
    check("rect_valid_late",   ovl.rect_valid, 0);
    step(1);
    check("rect_valid",        ovl.rect_valid, 1);
    check("rect_min_row",      ovl.rect_min_row, 200);
    check("rect_max_row",      ovl.rect_max_row, 240);
    check("rect_min_col",      ovl.rect_min_col, 320);
    check("rect_max_col",      ovl.rect_max_col, 360);

    // draw_en drop clears everything
    draw_en = 1'b0;
    step(3);
    check("drop_state",   ovl.rect_state, 0);
    check("drop_valid",   ovl.rect_valid, 0);
    check("drop_min_row", ovl.rect_min_row, 0);
    check("drop_max_col", ovl.rect_max_col, 0);

    // reset during a hold: home, then a full debounce before the next tick
    KEY = 4'b1110;
    step(8);  check("hold_moved", ovl.c_col, 368);
    reset = 1'b1;
    step(1);
    check("hold_reset_row", ovl.c_row, 240);
    check("hold_reset_col", ovl.c_col, 320);
    reset = 1'b0;
    step(4);  check("hold_no_tick4", ovl.c_col, 320);
    step(2);  check("hold_no_tick6", ovl.c_col, 320);
    step(1);  check("hold_tick",     ovl.c_col, 328);
    KEY = 4'hf;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cursor_rect_ctrl.md
Name: cursor_rect_ctrl

Overview:
Control-side sequencer for the cursor/rectangle overlay on the D8M camera VGA path. It debounces KEY[3:0] and applies press-and-hold auto-repeat to move a cursor with wrap-around, and runs the rectangle-lock FSM from the draw and lock switches. It outputs a registered cursor centre and normalized rectangle bounds that the overlay pixel datapath consumes directly. This replaces the free-running divided cursor clock with a single CLOCK_50 domain.

Parameters:
H_LIMIT, 640, horizontal active pixels; cursor column range is 0..H_LIMIT-1
V_LIMIT, 480, vertical active lines; cursor row range is 0..V_LIMIT-1
VELOCITY, 8, pixels moved per move tick
DEBOUNCE_CYCLES, 500000, cycles a synchronized key must stay stable before it is accepted (10 ms)
REPEAT_DELAY, 12500000, hold cycles from the first move to the first repeat (250 ms)
REPEAT_PERIOD, 2097152, hold cycles between subsequent repeats
HOME_ROW, 240, cursor row after reset or disable
HOME_COL, 320, cursor column after reset or disable

Ports:
CLOCK_50  in  1  sole clock
reset  in  1  synchronous, active-high
KEY  in  4  raw active-low keys: [3] left, [2] up, [1] down, [0] right
cursor_en  in  1  cursor enable (SW[0])
draw_en  in  1  rectangle mode (SW[5])
lock_sw  in  1  corner lock toggle (SW[6])
c_row  out  13  cursor centre row
c_col  out  13  cursor centre column
rect_min_row, rect_max_row, rect_min_col, rect_max_col  out  13 each  normalized rectangle bounds
rect_valid  out  1  rectangle bounds valid for drawing
rect_state  out  2  FSM state, for LED debug

Behaviour:
- One clock domain. Clock is CLOCK_50. Reset is synchronous and active-high.
- Reset values: c_row=HOME_ROW, c_col=HOME_COL, all rect bounds=0, rect_valid=0, rect_state=R_OFF.
- Reset also clears the debounce and repeat counters and any stored corner.
- KEY, cursor_en, draw_en and lock_sw each pass through a 2-FF synchronizer. lock_sw is then debounced the same way as the keys.
- Each key has its own debounce counter. A key's accepted state changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Active direction: the highest-priority accepted-pressed key, in the order left > up > down > right.
- Move tick behaviour:
  - A tick fires on the cycle the active direction first becomes pressed.
  - Further ticks fire REPEAT_DELAY cycles later, then every REPEAT_PERIOD cycles while the same direction stays active.
  - A change of active direction re-arms the sequence with an immediate tick.
  - Releasing all keys stops the ticks.
- Position update takes effect on the cycle after the tick. Arithmetic is unsigned and stays in range:
  - Left: if c_col >= VELOCITY, c_col -= VELOCITY; else c_col += H_LIMIT - VELOCITY.
  - Right: if c_col + VELOCITY < H_LIMIT, c_col += VELOCITY; else c_col += VELOCITY - H_LIMIT.
  - Up and down follow the same rules on c_row with V_LIMIT.
- When cursor_en=0: cursor goes to home, FSM is forced to R_OFF, and ticks are ignored.
- Rect FSM. All transitions are registered. draw_en=0 sends any state to R_OFF, and this has top priority.
  - R_OFF: bounds and corners are cleared, rect_valid=0. Goes to R_READY when cursor_en & draw_en.
  - R_READY: on lock_sw rising edge, capture P1=(c_row,c_col) and go to R_LOCK1.
  - R_LOCK1: the cursor moves freely. On lock_sw falling edge, capture P2=(c_row,c_col) and go to R_LOCK2.
  - R_LOCK2: rect_valid=1. On lock_sw rising edge, capture a new P1, set rect_valid=0, and go to R_LOCK1.
- Bounds are min/max of P1 and P2, registered one cycle after the P2 capture. rect_valid rises on that same cycle.
- If a tick and a lock edge occur in the same cycle, the captured corner uses the pre-move position.
- If P1 equals P2, bounds are degenerate, min equals max, and rect_valid=1 is still legal.
- Reset asserted mid-hold or mid-lock returns to reset values next cycle. A key still held after reset needs a full debounce period before it produces a tick.

Decomposition:
- Package cursor_pkg holds:
  - R_OFF=0, R_READY=1, R_LOCK1=2, R_LOCK2=3
  - the direction encoding
  - the 13-bit coordinate width constant
- One sub-module, key_debounce: synchronizer plus stable-count filter, parameterized by DEBOUNCE_CYCLES.
  - Instantiated once for each of the 4 keys and once for lock_sw.
- Auto-repeat, wrap arithmetic and the FSM stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Reset -> c_row=240, c_col=320, rect_valid=0, rect_state=0. Hold KEY[0] low 30 cycles -> c_col=328 after debounce, 336 after the first repeat.
2. KEY[1] bounces with a 2-cycle low glitch -> no movement. Then held 60 cycles -> rows 248, 256, 264, 272, 280 at the specified tick times.
3. Wrap: c_col=4, press left -> c_col=636. c_row=476, press down -> c_row=4.
4. KEY[3] and KEY[0] pressed together -> left wins, c_col decreases by 8.
5. Rectangle sequence:
   - draw_en=1.
   - Cursor at (240,320), lock_sw rises -> R_LOCK1.
   - Move to (200,360), lock_sw falls -> min_row=200, max_row=240, min_col=320, max_col=360, rect_valid=1.
6. While in R_LOCK2, draw_en drops -> next cycle rect_state=0, rect_valid=0, bounds=0. Separately, assert reset during a hold -> home position, no tick for 4 cycles after release of reset.
